// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
// Latency: n/a (types, constants and a combinational search function only).
// Backpressure: n/a.
package rr_arb_pkg;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Circular priority search: the first requester after last_idx wins,
    // so last_idx itself is checked last. The offset loop runs from the
    // farthest slot down to the nearest so the nearest hit is the one kept.
    // The result is meaningful only when |req is true.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0]     req,
                                                 input logic [IDX_W-1:0] last_idx);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] pick;
        pick = last_idx;
        for (int k = N; k >= 1; k--) begin
            idx = last_idx + k[IDX_W-1:0];
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter8_dec3to8.sv
// 3-to-8 one-hot decoder driving the grant select lines.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the index.
// Ports: a - 3-bit index in; y - one-hot 8-bit out with bit a set.
module dec3to8
    import rr_arb_pkg::*;
(
    input  logic [IDX_W-1:0] a,
    output logic [N-1:0]     y
);

    always_comb begin
        y    = '0;
        y[a] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter sharing one resource among 8 requesters, with a
// one-cycle break-before-make gap between grants.
// Latency: 1 cycle from req to registered gnt; releases take effect 1 cycle
// after req drops, followed by one dead gap cycle.
// Backpressure: a granted requester holds the resource until it drops req;
// others wait. With ARB_TIMEOUT_EN defined, a grant that has run MAX_HOLD
// cycles is forcibly rotated away when another requester is pending.
// Ports: clk, rst_n (async active-low); req[7:0] request vector;
// gnt[7:0] registered one-hot grant; gnt_idx current/last granted index;
// gnt_valid high while a grant is active (equals |gnt).
module rr_arbiter8
    import rr_arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
    parameter int MAX_HOLD = 16
)
`endif
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    arb_state_t       state;
    arb_state_t       nxt_state;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] nxt_last;
    logic [IDX_W-1:0] nxt_idx;
    logic             nxt_valid;
    logic [IDX_W-1:0] winner;
    logic [N-1:0]     dec_out;
    logic             release_now;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic [7:0] nxt_hold;
    logic       hold_sat;
    logic       others_pending;

    assign hold_sat       = (hold_cnt == 8'(MAX_HOLD - 1));
    // gnt is the one-hot of gnt_idx while in GRANT, so masking it off
    // leaves only the competing requesters.
    assign others_pending = |(req & ~gnt);
    assign release_now    = !req[gnt_idx] || (hold_sat && others_pending);
`else
    assign release_now    = !req[gnt_idx];
`endif

    assign winner = rr_pick(req, last_idx);

    always_comb begin
        nxt_state = state;
        nxt_last  = last_idx;
        nxt_idx   = gnt_idx;
        nxt_valid = 1'b0;
`ifdef ARB_TIMEOUT_EN
        nxt_hold  = hold_cnt;
`endif
        case (state)
            IDLE, GAP: begin
                if (|req) begin
                    nxt_state = GRANT;
                    nxt_idx   = winner;
                    nxt_valid = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    nxt_hold  = '0;
`endif
                end else begin
                    nxt_state = IDLE;
                end
            end
            GRANT: begin
                if (release_now) begin
                    // Releasing index becomes the pointer so it gets the
                    // lowest priority in the arbitration during GAP.
                    nxt_state = GAP;
                    nxt_last  = gnt_idx;
                end else begin
                    nxt_valid = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    if (!hold_sat) begin
                        nxt_hold = hold_cnt + 8'd1;
                    end
`endif
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    dec3to8 u_dec (
        .a (nxt_idx),
        .y (dec_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_idx  <= 3'd7;
            gnt_idx   <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= nxt_state;
            last_idx  <= nxt_last;
            gnt_idx   <= nxt_idx;
            gnt       <= dec_out & {N{nxt_valid}};
            gnt_valid <= nxt_valid;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= nxt_hold;
        end
    end
`endif

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
Round-robin arbiter that shares one resource among 8 requesters. It selects the next requester circularly after the last one granted. It issues the grant both as a 3-bit index and as an 8-bit one-hot vector; the one-hot vector comes from a 3-to-8 decoder sub-module. It sits in front of any shared datapath slot whose select lines are driven by a 3-to-8 decode.

Parameters:
N, 8, number of requesters (fixed at 8 in this revision)
IDX_W, 3, width of grant index (log2 N)
MAX_HOLD, 16, max consecutive grant cycles before forced rotation (used only with ARB_TIMEOUT_EN; legal range 2..255)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  8  request vector; requester i holds req[i] high while it needs or is using the resource
gnt  output  8  registered one-hot grant; all zero when no grant
gnt_idx  output  3  registered index of current/last grant
gnt_valid  output  1  high while a grant is active; equals |gnt

Behaviour:
- Reset (async assert, sync release): gnt=0, gnt_idx=0, gnt_valid=0, state=IDLE, last_idx=7 (so first priority is index 0), hold_cnt=0.
- Arbitration function (combinational): scan indices (last_idx+1)..(last_idx+8) mod 8; pick the first i with req[i]=1.
- States: IDLE, GRANT, GAP.
- IDLE: gnt=0. If |req, the winner is registered at the next edge: gnt_idx=winner, gnt=decode(winner), gnt_valid=1, hold_cnt=0, go to GRANT. Latency from req asserted to gnt is 1 cycle.
- GRANT, req[gnt_idx] still high: hold the grant, hold_cnt increments and saturates at MAX_HOLD-1. Requests from other indices never preempt the grant, except under the timeout rule below.
- GRANT, req[gnt_idx]=0: at the next edge gnt=0, gnt_valid=0, last_idx=gnt_idx, go to GAP. gnt_idx keeps its value.
- GAP: lasts exactly 1 cycle with gnt=0. The winner is evaluated from req and last_idx in this cycle. If |req, go to GRANT with the new winner; otherwise go to IDLE.
  - Guarantees at least one dead cycle between any two grants (break-before-make).
  - The releasing requester has the lowest priority in the following arbitration.
- gnt is always either 0 or decode(gnt_idx); never more than one bit set.
- req changes on non-granted lines during GRANT have no effect on outputs.
- A requester that drops req before being granted is simply skipped; there is no request latching.
- Reset mid-grant: outputs clear immediately (asynchronous). The pointer returns to last_idx=7.
- No X propagation: req bits are treated as-is; the bench drives known values only.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined: in GRANT, if hold_cnt==MAX_HOLD-1 and any req[j]=1 with j!=gnt_idx, the grant is forcibly dropped at the next edge. Then last_idx=gnt_idx and the state goes to GAP, exactly as for a voluntary release. The dropped requester re-competes with lowest priority.
- Defined, no other requester pending: the grant continues and hold_cnt stays saturated.
- Not defined: hold_cnt logic and MAX_HOLD are unused (may be removed). A grant lasts until its req drops.

Decomposition:
- Package rr_arb_pkg holds:
  - constants N=8 and IDX_W=3;
  - state encoding IDLE=2'd0, GRANT=2'd1, GAP=2'd2;
  - the circular-priority search function.
- Sub-module dec3to8 (purely combinational 3-bit in, 8-bit one-hot out) produces decode(gnt_idx).
  - Its output is ANDed with gnt_valid and registered into gnt.

Test Plan:
1. After reset, req=8'h01 at cycle 0 -> gnt=8'h01, gnt_idx=0, gnt_valid=1 at cycle 1. Drop req at cycle 3 -> gnt=0 at cycle 4, state GAP then IDLE.
2. After reset, req=8'h84 held -> gnt=8'h04 (idx 2). Clear req[2] -> exactly one cycle with gnt=0, then gnt=8'h80 (idx 7).
3. Wrap-around: after idx 7 releases, req=8'h81 -> next grant is idx 0 (8'h01), not idx 7.
4. Fairness: req=8'hFF; each granted requester drops its req after 2 grant cycles, then reasserts it one cycle later -> grant sequence 0,1,2,...,7,0, with a 1-cycle gap between each.
5. ARB_TIMEOUT_EN, MAX_HOLD=4, req=8'h03 held:
   - idx 0 for 4 cycles, gap, idx 1 for 4 cycles, gap, idx 0 again.
   - Without the macro: idx 0 is held indefinitely.
   - With the macro and req=8'h01 only: idx 0 is held beyond 4 cycles.
6. Assert rst_n=0 mid-grant (gnt=8'h20) between clock edges -> gnt=0 and gnt_valid=0 immediately. After release with req=8'h21, the first grant is idx 0.
